usrt_apb_front: RTL and testbench

- APB slave front-end of the USRT bridge.
- Decodes APB transfers into a small register file.
- Buffers outgoing bytes in a TX FIFO that feeds the serializer through a valid/ready byte handshake.
- Buffers bytes delivered by the deserializer in an RX FIFO that the host drains over APB.

---
 rtl/usrt_apb_front.sv | 176 +++++++++++++++++
 tb/tb_usrt_apb_front.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/usrt_apb_front.sv
// usrt_apb_front: APB slave front-end of the USRT bridge.
// Holds the register file, a TX FIFO that feeds the serializer
// and an RX FIFO that the host drains over APB.
// Ports:
//   pClk, pReset          clock, synchronous active-low reset
//   pSelect .. pWData     APB request
//   pRData/pReady/pSlvErr APB response, valid while pReady=1
//   tx_data/valid/ready   byte handshake towards the serializer
//   rx_data/valid         byte strobe from the deserializer
//   usrt_en, irq          CTRL.EN and the level interrupt
module usrt_apb_front #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              pSelect,
    input  logic              pEnable,
    input  logic              pWrite,
    input  logic [ADDR_W-1:0] pAddress,
    input  logic [7:0]        pWData,
    output logic [7:0]        pRData,
    output logic              pReady,
    output logic              pSlvErr,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              usrt_en,
    output logic              irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t state_q, state_d;

    logic [7:0]    txm_q [FIFO_DEPTH];
    logic [7:0]    rxm_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [AW:0]   tx_cnt_q, rx_cnt_q;
    logic          en_q, rxie_q, ovr_q, irq_q;
    logic [7:0]    rdata_q, rdata_d;
    logic          err_q, err_d;

    logic commit, dec_ok, sel_data, sel_stat, sel_ctrl;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_flush, rx_flush, ovr_set, ovr_clr, ctrl_wr;

    // Side effects happen only on the WAIT->DONE edge.
    assign commit   = (state_q == S_WAIT) && pSelect;
    assign dec_ok   = (pAddress[ADDR_W-1:4] == '0);
    assign sel_data = dec_ok && (pAddress[3:0] == 4'h0);
    assign sel_stat = dec_ok && (pAddress[3:0] == 4'h4);
    assign sel_ctrl = dec_ok && (pAddress[3:0] == 4'h8);

    assign tx_full  = (tx_cnt_q == CNT_FULL);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CNT_FULL);
    assign rx_empty = (rx_cnt_q == '0);

    assign ctrl_wr  = commit && pWrite && sel_ctrl;
    assign tx_flush = ctrl_wr && pWData[1];
    assign rx_flush = ctrl_wr && pWData[2];
    assign ovr_clr  = ctrl_wr && pWData[4];

    assign tx_valid = en_q && !tx_empty;
    assign tx_data  = txm_q[tx_rp_q];
    assign tx_push  = commit && pWrite && sel_data && !tx_full;
    assign tx_pop   = tx_valid && tx_ready;

    // A full RX FIFO still accepts a byte if the host pops the same edge.
    assign rx_pop   = commit && !pWrite && sel_data && !rx_empty;
    assign rx_push  = rx_valid && (!rx_full || rx_pop);
    assign ovr_set  = rx_valid && rx_full && !rx_pop;

    assign pReady  = (state_q == S_DONE);
    assign pRData  = rdata_q;
    assign pSlvErr = err_q;
    assign usrt_en = en_q;
    assign irq     = irq_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pSelect && pEnable) state_d = S_WAIT;
            S_WAIT:  state_d = pSelect ? S_DONE : S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = 8'h00;
        err_d   = 1'b0;
        if (commit) begin
            if (sel_data) begin
                if (pWrite) begin
                    err_d = tx_full;
                end else if (rx_empty) begin
                    err_d = 1'b1;
                end else begin
                    rdata_d = rxm_q[rx_rp_q];
                end
            end else if (sel_stat) begin
                if (pWrite) err_d = 1'b1;
                else rdata_d = {3'b000, ovr_q, rx_empty,
                                rx_full, tx_empty, tx_full};
            end else if (sel_ctrl) begin
                if (!pWrite) rdata_d = {4'h0, rxie_q, 2'b00, en_q};
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pClk) begin
        if (!pReset) begin
            state_q  <= S_IDLE;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            en_q     <= 1'b0;
            rxie_q   <= 1'b0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            irq_q   <= (rxie_q && !rx_empty) || ovr_q;
            if (ctrl_wr) begin
                en_q   <= pWData[0];
                rxie_q <= pWData[3];
            end
            if (ovr_set) ovr_q <= 1'b1;
            else if (ovr_clr) ovr_q <= 1'b0;
            if (tx_flush) begin
                tx_wp_q  <= '0;
                tx_rp_q  <= '0;
                tx_cnt_q <= '0;
            end else begin
                if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
                if (tx_pop) tx_rp_q <= tx_rp_q + 1'b1;
                if (tx_push && !tx_pop) tx_cnt_q <= tx_cnt_q + 1'b1;
                if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
            end
            if (rx_flush) begin
                rx_wp_q  <= '0;
                rx_rp_q  <= '0;
                rx_cnt_q <= '0;
            end else begin
                if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
                if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
                if (rx_push && !rx_pop) rx_cnt_q <= rx_cnt_q + 1'b1;
                if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; pointers and counts define validity.
    always_ff @(posedge pClk) begin
        if (tx_push && !tx_flush) txm_q[tx_wp_q] <= pWData;
        if (rx_push && !rx_flush) rxm_q[rx_wp_q] <= rx_data;
    end

endmodule

// File: tb/tb_usrt_apb_front.sv
// tb_usrt_apb_front: directed bench for usrt_apb_front.
// Expected APB responses and TX bytes are queued then popped on output.
module tb_usrt_apb_front;

    logic       pClk = 1'b0;
    logic       pReset;
    logic       pSelect, pEnable, pWrite;
    logic [7:0] pAddress, pWData;
    logic [7:0] pRData;
    logic       pReady, pSlvErr;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       usrt_en, irq;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q [$];
    logic [7:0] tx_q  [$];

    usrt_apb_front #(.FIFO_DEPTH(4), .ADDR_W(8)) dut (
        .pClk     (pClk),
        .pReset   (pReset),
        .pSelect  (pSelect),
        .pEnable  (pEnable),
        .pWrite   (pWrite),
        .pAddress (pAddress),
        .pWData   (pWData),
        .pRData   (pRData),
        .pReady   (pReady),
        .pSlvErr  (pSlvErr),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .usrt_en  (usrt_en),
        .irq      (irq)
    );

    always #5 pClk = ~pClk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: plain transfer; 1: rx strobe on the WAIT->DONE edge;
    // 2: reset asserted during WAIT (no response expected).
    task automatic apb(input string tag, input logic wr,
                       input logic [7:0] addr, input logic [7:0] wd,
                       input int mode, input logic [7:0] rxb);
        int n;
        logic [8:0] e;
        @(negedge pClk);
        pSelect = 1'b1; pEnable = 1'b0;
        pWrite = wr; pAddress = addr; pWData = wd;
        @(negedge pClk);
        pEnable = 1'b1;
        n = 0;
        while (n < 8) begin
            @(posedge pClk); #1;
            n++;
            if (pReady) break;
            if (n == 1 && mode == 1) begin
                rx_valid = 1'b1; rx_data = rxb;
            end
            if (n == 1 && mode == 2) begin
                pReset = 1'b0;
                @(posedge pClk); #1;
                chk({tag, "_rst_ready"}, 32'(pReady), 0);
                chk({tag, "_rst_err"}, 32'(pSlvErr), 0);
                pReset = 1'b1;
                pSelect = 1'b0; pEnable = 1'b0;
                return;
            end
        end
        rx_valid = 1'b0;
        chk({tag, "_lat"}, n, 2);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, 32'(pRData), 32'(e[7:0]));
            chk({tag, "_err"}, 32'(pSlvErr), 32'(e[8]));
        end
        pSelect = 1'b0; pEnable = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic wr,
                        input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] er, input logic ee);
        exp_q.push_back({ee, er});
        apb(tag, wr, addr, wd, 0, 8'h00);
    endtask

    task automatic rx_strobe(input logic [7:0] d);
        @(negedge pClk);
        rx_valid = 1'b1; rx_data = d;
        @(negedge pClk);
        rx_valid = 1'b0;
    endtask

    task automatic tx_pulse(input string tag);
        @(negedge pClk);
        chk({tag, "_valid"}, 32'(tx_valid), 1);
        if (tx_q.size() != 0)
            chk({tag, "_data"}, 32'(tx_data), 32'(tx_q.pop_front()));
        tx_ready = 1'b1;
        @(negedge pClk);
        tx_ready = 1'b0;
    endtask

    initial begin
        pReset = 1'b0; pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
        pAddress = 8'h00; pWData = 8'h00; tx_ready = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) @(posedge pClk);
        #1;
        chk("rst_rdata", 32'(pRData), 0);
        chk("rst_ready", 32'(pReady), 0);
        chk("rst_err", 32'(pSlvErr), 0);
        chk("rst_txv", 32'(tx_valid), 0);
        chk("rst_en", 32'(usrt_en), 0);
        chk("rst_irq", 32'(irq), 0);
        pReset = 1'b1;

        xfer("stat0", 1'b0, 8'h04, 8'h00, 8'h0A, 1'b0);

        xfer("ctrl_en", 1'b1, 8'h08, 8'h01, 8'h00, 1'b0);
        @(negedge pClk);
        chk("usrt_en", 32'(usrt_en), 1);
        xfer("w_a5", 1'b1, 8'h00, 8'hA5, 8'h00, 1'b0);
        tx_q.push_back(8'hA5);
        xfer("w_3c", 1'b1, 8'h00, 8'h3C, 8'h00, 1'b0);
        tx_q.push_back(8'h3C);
        tx_pulse("tx0");
        tx_pulse("tx1");
        @(negedge pClk);
        chk("tx_drained", 32'(tx_valid), 0);
        xfer("stat1", 1'b0, 8'h04, 8'h00, 8'h0A, 1'b0);

        xfer("ctrl_dis", 1'b1, 8'h08, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++)
            xfer("w_fill", 1'b1, 8'h00, 8'(i), 8'h00, i == 4);
        chk("txv_en0", 32'(tx_valid), 0);
        xfer("stat_txf", 1'b0, 8'h04, 8'h00, 8'h09, 1'b0);
        xfer("ctrl_fl", 1'b1, 8'h08, 8'h03, 8'h00, 1'b0);
        xfer("stat_fl", 1'b0, 8'h04, 8'h00, 8'h0A, 1'b0);
        xfer("ctrl_rd", 1'b0, 8'h08, 8'h00, 8'h01, 1'b0);
        chk("txv_fl", 32'(tx_valid), 0);

        rx_strobe(8'h11); rx_strobe(8'h22); rx_strobe(8'h33);
        rx_strobe(8'h44); rx_strobe(8'h55);
        xfer("stat_ovr", 1'b0, 8'h04, 8'h00, 8'h16, 1'b0);
        chk("irq_ovr", 32'(irq), 1);
        xfer("r_11", 1'b0, 8'h00, 8'h00, 8'h11, 1'b0);
        xfer("r_22", 1'b0, 8'h00, 8'h00, 8'h22, 1'b0);
        xfer("r_33", 1'b0, 8'h00, 8'h00, 8'h33, 1'b0);
        xfer("r_44", 1'b0, 8'h00, 8'h00, 8'h44, 1'b0);
        xfer("r_empty", 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        xfer("ovr_clr", 1'b1, 8'h08, 8'h11, 8'h00, 1'b0);
        xfer("stat_clr", 1'b0, 8'h04, 8'h00, 8'h0A, 1'b0);
        chk("irq_clr", 32'(irq), 0);

        xfer("ctrl_ie", 1'b1, 8'h08, 8'h09, 8'h00, 1'b0);
        rx_strobe(8'hA1);
        @(negedge pClk);
        chk("irq_rxie", 32'(irq), 1);
        rx_strobe(8'hA2); rx_strobe(8'hA3); rx_strobe(8'hA4);
        exp_q.push_back({1'b0, 8'hA1});
        apb("r_coinc", 1'b0, 8'h00, 8'h00, 1, 8'h77);
        xfer("stat_co", 1'b0, 8'h04, 8'h00, 8'h06, 1'b0);
        xfer("r_a2", 1'b0, 8'h00, 8'h00, 8'hA2, 1'b0);
        xfer("r_a3", 1'b0, 8'h00, 8'h00, 8'hA3, 1'b0);
        xfer("r_a4", 1'b0, 8'h00, 8'h00, 8'hA4, 1'b0);
        xfer("r_77", 1'b0, 8'h00, 8'h00, 8'h77, 1'b0);

        xfer("bad_addr", 1'b0, 8'h0C, 8'h00, 8'h00, 1'b1);
        xfer("hi_addr", 1'b0, 8'h84, 8'h00, 8'h00, 1'b1);
        xfer("w_stat", 1'b1, 8'h04, 8'hFF, 8'h00, 1'b1);

        apb("w_rst", 1'b1, 8'h00, 8'h99, 2, 8'h00);
        xfer("stat_rst", 1'b0, 8'h04, 8'h00, 8'h0A, 1'b0);
        chk("en_rst", 32'(usrt_en), 0);
        chk("txv_rst", 32'(tx_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
